// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: one byte per txStart, 8N1/8N2 framing on tx, txBusy for the frame.
// Optional parity bit between data and stop when UART_TX_PARITY_EN is defined.
module uart_tx_serializer #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       txStart,
    input  logic [7:0] txData,
    output logic       txBusy,
    output logic       tx
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);
    localparam logic [2:0] LastStop = 3'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535 || STOP_BITS < 1 || STOP_BITS > 2 ||
        PARITY_ODD > 1) begin : g_param_check
        $error("uart_tx_serializer: illegal parameter value");
    end

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_TX_PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              bit_done;
`ifdef UART_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    assign bit_done = (baud_q == CntMax);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        if (state_q != StIdle) begin
            baud_d = bit_done ? '0 : baud_q + CntW'(1);
        end
        unique case (state_q)
            StIdle: begin
                if (txStart) begin
                    shift_d = txData;
                    busy_d  = 1'b1;
                    tx_d    = 1'b0;
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = StStart;
`ifdef UART_TX_PARITY_EN
                    parity_d = (^txData) ^ PARITY_ODD[0];
`endif
                end
            end
            StStart: begin
                if (bit_done) begin
                    tx_d    = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                    state_d = StData;
                end
            end
            StData: begin
                if (bit_done) begin
                    if (bit_q == 3'd7) begin
                        bit_d   = '0;
`ifdef UART_TX_PARITY_EN
                        tx_d    = parity_q;
                        state_d = StParity;
`else
                        tx_d    = 1'b1;
                        state_d = StStop;
`endif
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        tx_d    = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (bit_done) begin
                    tx_d    = 1'b1;
                    state_d = StStop;
                end
            end
`endif
            StStop: begin
                // bit_q counts stop bits here so 8N2 reuses the same counter
                if (bit_done) begin
                    if (bit_q == LastStop) begin
                        busy_d  = 1'b0;
                        tx_d    = 1'b1;
                        bit_d   = '0;
                        state_d = StIdle;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            default: begin
                busy_d  = 1'b0;
                tx_d    = 1'b1;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign tx     = tx_q;
    assign txBusy = busy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: frames are decoded at bit centres and compared
// against bytes and frame lengths derived from the 8N1 (or 8E1/8O1) framing rules.
module tb_uart_tx_serializer;

    localparam int unsigned Cpb  = 4;
    localparam int unsigned Stop = 1;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned Par = 1;
`else
    localparam int unsigned Par = 0;
`endif
    localparam int unsigned NBits  = 1 + 8 + Par + Stop;
    localparam int unsigned FrameLen = NBits * Cpb;
    localparam int unsigned MaxCyc = FrameLen + 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       txStart = 1'b0;
    logic [7:0] txData = 8'h00;
    logic       txBusy, tx;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_serializer #(
        .CLKS_PER_BIT(Cpb),
        .STOP_BITS   (Stop),
        .PARITY_ODD  (0)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .txStart(txStart),
        .txData (txData),
        .txBusy (txBusy),
        .tx     (tx)
    );

`ifdef UART_TX_PARITY_EN
    logic txBusy_odd, tx_odd;
    uart_tx_serializer #(
        .CLKS_PER_BIT(Cpb),
        .STOP_BITS   (Stop),
        .PARITY_ODD  (1)
    ) dut_odd (
        .clk    (clk),
        .rst    (rst),
        .txStart(txStart),
        .txData (txData),
        .txBusy (txBusy_odd),
        .tx     (tx_odd)
    );
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a byte for one cycle; returns #1 after the accepting edge.
    task automatic pulse(input logic [7:0] d);
        txData  = d;
        txStart = 1'b1;
        tick();
        txStart = 1'b0;
        txData  = 8'($urandom);
    endtask

    // Observe one frame (no comparisons): bit-centre samples, busy length, tx when busy falls.
    // inj_j >= 0 raises txStart with inj_d at that cycle of the frame.
    task automatic capture(input int inj_j, input logic [7:0] inj_d,
                           output logic [7:0] data, output logic startb, output logic stopb,
                           output logic parb, output logic parb_odd,
                           output int busy_len, output logic tx_at_fall);
        logic bits [0:NBits-1];
        logic bits_odd [0:NBits-1];
        int j = 0;
        for (int i = 0; i < int'(NBits); i++) begin
            bits[i] = 1'bx;
            bits_odd[i] = 1'bx;
        end
        busy_len = 0;
        while (txBusy === 1'b1 && j < int'(MaxCyc)) begin
            if (j % Cpb == Cpb / 2 && j / Cpb < NBits) begin
                bits[j / Cpb] = tx;
`ifdef UART_TX_PARITY_EN
                bits_odd[j / Cpb] = tx_odd;
`endif
            end
            if (j == inj_j) begin
                txStart = 1'b1;
                txData  = inj_d;
            end else if (j == inj_j + 1) begin
                txStart = 1'b0;
            end
            busy_len++;
            j++;
            tick();
        end
        txStart    = 1'b0;
        tx_at_fall = tx;
        startb     = bits[0];
        for (int i = 0; i < 8; i++) data[i] = bits[1 + i];
        stopb    = bits[9 + Par];
        parb     = (Par != 0) ? bits[9] : 1'b0;
        parb_odd = (Par != 0) ? bits_odd[9] : 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            checks++;
            if (tx !== 1'b1 || txBusy !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: tx=%b busy=%b, want tx=1 busy=0",
                         c, tx, txBusy);
            end
            tick();
        end
    endtask

    task automatic test_single_byte();
        logic [7:0] d;
        logic s, p, po, f, st;
        int len;
        pulse(8'h55);
        checks++;
        if (txBusy !== 1'b1 || tx !== 1'b0) begin
            errors++;
            $display("FAIL single_latency: busy=%b tx=%b, want busy=1 tx=0", txBusy, tx);
        end
        capture(-1, 8'h00, d, s, st, p, po, len, f);
        checks++;
        if (d !== 8'h55 || s !== 1'b0 || st !== 1'b1) begin
            errors++;
            $display("FAIL single_decode: data=%h start=%b stop=%b, want 55 0 1", d, s, st);
        end
        checks++;
        if (len != int'(FrameLen) || f !== 1'b1) begin
            errors++;
            $display("FAIL single_busy_len: len=%0d tx_at_fall=%b, want %0d 1", len, f, FrameLen);
        end
    endtask

    task automatic test_ignore_busy();
        logic [7:0] d;
        logic s, p, po, f, st;
        int len, extra;
        repeat (3) tick();
        pulse(8'hA3);
        capture(15, 8'hFF, d, s, st, p, po, len, f);
        checks++;
        if (d !== 8'hA3 || len != int'(FrameLen)) begin
            errors++;
            $display("FAIL ignore_busy: data=%h len=%0d, want a3 %0d", d, len, FrameLen);
        end
        extra = 0;
        for (int c = 0; c < int'(3 * Cpb); c++) begin
            if (txBusy !== 1'b0 || tx !== 1'b1) extra++;
            tick();
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL ignore_no_second: non-idle cycles=%0d, want 0", extra);
        end
    endtask

    // Upstream buffer model: pushes the next byte as soon as txBusy is seen low.
    task automatic test_back_to_back();
        logic [7:0] q [$];
        logic [7:0] d, want;
        logic s, p, po, f, st;
        int len;
        q = '{8'h00, 8'hFF, 8'h81};
        for (int n = 0; n < 4; n++) q.push_back(8'($urandom));
        while (q.size() > 0) begin
            checks++;
            if (txBusy !== 1'b0 || tx !== 1'b1) begin
                errors++;
                $display("FAIL b2b_gap: busy=%b tx=%b before push, want 0 1", txBusy, tx);
            end
            want = q.pop_front();
            pulse(want);
            capture(-1, 8'h00, d, s, st, p, po, len, f);
            checks++;
            if (d !== want || s !== 1'b0 || st !== 1'b1 || len != int'(FrameLen)) begin
                errors++;
                $display("FAIL b2b_frame: data=%h start=%b stop=%b len=%0d, want %h 0 1 %0d",
                         d, s, st, len, want, FrameLen);
            end
        end
    endtask

    task automatic test_random_gaps();
        logic [7:0] d, want;
        logic s, p, po, f, st;
        int len;
        for (int n = 0; n < 6; n++) begin
            repeat ($urandom_range(0, 3)) tick();
            want = 8'($urandom);
            pulse(want);
            capture(-1, 8'h00, d, s, st, p, po, len, f);
            checks++;
            if (d !== want || len != int'(FrameLen) || f !== 1'b1) begin
                errors++;
                $display("FAIL random_frame %0d: data=%h len=%0d fall_tx=%b, want %h %0d 1",
                         n, d, len, f, want, FrameLen);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        logic s, p, po, f, st;
        int len;
        repeat (2) tick();
        pulse(8'h3C);
        repeat (18) tick();
        rst = 1'b1;
        tick();
        checks++;
        if (tx !== 1'b1 || txBusy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_abort: tx=%b busy=%b, want 1 0", tx, txBusy);
        end
        rst = 1'b0;
        repeat (2 * Cpb) tick();
        checks++;
        if (tx !== 1'b1 || txBusy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_no_resume: tx=%b busy=%b, want 1 0", tx, txBusy);
        end
        pulse(8'h96);
        capture(-1, 8'h00, d, s, st, p, po, len, f);
        checks++;
        if (d !== 8'h96 || s !== 1'b0 || st !== 1'b1 || len != int'(FrameLen)) begin
            errors++;
            $display("FAIL midreset_clean: data=%h start=%b stop=%b len=%0d, want 96 0 1 %0d",
                     d, s, st, len, FrameLen);
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [7:0] d, want;
        logic s, p, po, f, st, want_even;
        int len;
        for (int n = 0; n < 4; n++) begin
            want = (n == 0) ? 8'h07 : 8'($urandom);
            want_even = logic'($countones(want) % 2);
            repeat (2) tick();
            pulse(want);
            capture(-1, 8'h00, d, s, st, p, po, len, f);
            checks++;
            if (d !== want || len != int'(FrameLen) || p !== want_even || po !== ~want_even) begin
                errors++;
                $display("FAIL parity %h: data=%h len=%0d even=%b odd=%b, want len %0d %b %b",
                         want, d, len, p, po, FrameLen, want_even, ~want_even);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_byte();
        test_ignore_busy();
        test_back_to_back();
        test_random_gaps();
        test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
